// File: rtl/fpga_top_if.sv
// Burst-generator bus: trigger input plus 16-lane complex sample output with valid.
interface fpga_top_if;
    logic               start_trigger;
    logic signed [12:0] dout_i [15:0];
    logic signed [12:0] dout_q [15:0];
    logic               dout_valid;

    modport master (output start_trigger, input dout_i, input dout_q, input dout_valid);
    modport slave  (input start_trigger, output dout_i, output dout_q, output dout_valid);
endinterface

// File: rtl/fpga_top.sv
// 512-point complex-exponential burst generator, 16 lanes/beat, with optional lane butterfly.
// Define FPGA_TOP_BFLY_EN to compile in the butterfly; otherwise raw samples pass through.
module fpga_top #(
    parameter int TONE_K = 4,
    parameter int AMP    = 2000
) (
    input logic      clk,
    input logic      rst,
    fpga_top_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Elaboration-time sample; Taylor series on an angle folded into [-pi, pi).
    function automatic logic signed [11:0] tone_sample(input int n, input bit quad);
        real pi;
        real ang;
        real x2;
        real term;
        real c;
        real s;
        real v;
        int  m;
        pi = 3.14159265358979323846;
        m  = (TONE_K * n) % 512;
        if (m >= 256) m = m - 512;
        ang = 2.0 * pi * m / 512.0;
        x2  = ang * ang;
        term = 1.0;
        c    = 1.0;
        for (int k = 1; k <= 16; k++) begin
            term = -term * x2 / ((2 * k - 1) * (2 * k));
            c    = c + term;
        end
        term = ang;
        s    = ang;
        for (int k = 1; k <= 16; k++) begin
            term = -term * x2 / ((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        v = AMP * (quad ? s : c);
        v = (v >= 0.0) ? v + 0.5 : v - 0.5;
        return 12'($rtoi(v));
    endfunction

    logic signed [11:0] tbl_i [512];
    logic signed [11:0] tbl_q [512];

    for (genvar n = 0; n < 512; n++) begin : g_tbl
        localparam logic signed [11:0] SampI = tone_sample(n, 1'b0);
        localparam logic signed [11:0] SampQ = tone_sample(n, 1'b1);
        assign tbl_i[n] = SampI;
        assign tbl_q[n] = SampQ;
    end

    logic [0:0] state_q, state_d;
    logic [4:0] beat_q, beat_d;
    logic       trig_q, trig_qq;
    logic       rise;
    logic       run;

    assign rise = trig_q & ~trig_qq;
    assign run  = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = RUN;
                    beat_d  = 5'd0;
                end
            end
            RUN: begin
                beat_d = beat_q + 5'd1;
                if (beat_q == 5'd31) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 5'd0;
            trig_q  <= 1'b0;
            trig_qq <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            trig_q  <= bus.start_trigger;
            trig_qq <= trig_q;
        end
    end

    logic signed [11:0] x_i [16];
    logic signed [11:0] x_q [16];
    logic signed [12:0] nxt_i [16];
    logic signed [12:0] nxt_q [16];

    for (genvar j = 0; j < 16; j++) begin : g_lane
        assign x_i[j] = tbl_i[{beat_q, 4'(j)}];
        assign x_q[j] = tbl_q[{beat_q, 4'(j)}];
    end

`ifdef FPGA_TOP_BFLY_EN
    for (genvar j = 0; j < 8; j++) begin : g_bfly
        assign nxt_i[j]     = {x_i[j][11], x_i[j]} + {x_i[j + 8][11], x_i[j + 8]};
        assign nxt_q[j]     = {x_q[j][11], x_q[j]} + {x_q[j + 8][11], x_q[j + 8]};
        assign nxt_i[j + 8] = {x_i[j][11], x_i[j]} - {x_i[j + 8][11], x_i[j + 8]};
        assign nxt_q[j + 8] = {x_q[j][11], x_q[j]} - {x_q[j + 8][11], x_q[j + 8]};
    end
`else
    for (genvar j = 0; j < 16; j++) begin : g_raw
        assign nxt_i[j] = {x_i[j][11], x_i[j]};
        assign nxt_q[j] = {x_q[j][11], x_q[j]};
    end
`endif

    logic signed [12:0] dout_i_q [16];
    logic signed [12:0] dout_q_q [16];
    logic               valid_q;

    // Lanes are zeroed whenever no beat is issued, so idle outputs read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            for (int j = 0; j < 16; j++) begin
                dout_i_q[j] <= '0;
                dout_q_q[j] <= '0;
            end
        end else begin
            valid_q <= run;
            for (int j = 0; j < 16; j++) begin
                dout_i_q[j] <= run ? nxt_i[j] : 13'sd0;
                dout_q_q[j] <= run ? nxt_q[j] : 13'sd0;
            end
        end
    end

    for (genvar j = 0; j < 16; j++) begin : g_out
        assign bus.dout_i[j] = dout_i_q[j];
        assign bus.dout_q[j] = dout_q_q[j];
    end
    assign bus.dout_valid = valid_q;

endmodule

// File: tb/tb_fpga_top.sv
// Directed bench for fpga_top: vector table on the first burst plus trigger/reset corner sequences.
module tb_fpga_top;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fpga_top_if bus ();

    fpga_top #(.TONE_K(4), .AMP(2000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [12:0] cap_i [64][16];
    logic signed [12:0] cap_q [64][16];
    int exp_i [32][16];
    int exp_q [32][16];

    typedef struct {
        string name;
        int    beat;
        int    lane;
        int    want_i;
        int    want_q;
    } vec_t;

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic build_model();
        int xi [512];
        int xq [512];
        real ang;
        for (int n = 0; n < 512; n++) begin
            ang   = 2.0 * 3.14159265358979323846 * 4.0 * n / 512.0;
            xi[n] = rnd(2000.0 * $cos(ang));
            xq[n] = rnd(2000.0 * $sin(ang));
        end
        for (int b = 0; b < 32; b++) begin
            for (int j = 0; j < 8; j++) begin
`ifdef FPGA_TOP_BFLY_EN
                exp_i[b][j]     = xi[16 * b + j] + xi[16 * b + j + 8];
                exp_q[b][j]     = xq[16 * b + j] + xq[16 * b + j + 8];
                exp_i[b][j + 8] = xi[16 * b + j] - xi[16 * b + j + 8];
                exp_q[b][j + 8] = xq[16 * b + j] - xq[16 * b + j + 8];
`else
                exp_i[b][j]     = xi[16 * b + j];
                exp_q[b][j]     = xq[16 * b + j];
                exp_i[b][j + 8] = xi[16 * b + j + 8];
                exp_q[b][j + 8] = xq[16 * b + j + 8];
`endif
            end
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_beat(input string name, input int slot, input int beat);
        int bad;
        bad = -1;
        for (int j = 0; j < 16; j++) begin
            if (bad < 0 && (cap_i[slot][j] != exp_i[beat][j] || cap_q[slot][j] != exp_q[beat][j]))
                bad = j;
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s beat %0d lane %0d: got (%0d,%0d), required (%0d,%0d)", name, beat, bad,
                     cap_i[slot][bad], cap_q[slot][bad], exp_i[beat][bad], exp_q[beat][bad]);
        end
    endtask

    task automatic check_zero_now(input string name);
        int nz;
        nz = 0;
        for (int j = 0; j < 16; j++) if (bus.dout_i[j] != 0 || bus.dout_q[j] != 0) nz++;
        check_int({name, "_valid"}, int'(bus.dout_valid), 0);
        check_int({name, "_lanes_nonzero"}, nz, 0);
    endtask

    // Iteration k samples at negedge k, then drives pat[k]; a pulse at k=0 gives first beat at k=3.
    task automatic watch(input int cycles, input logic [255:0] pat, output int nvalid,
                         output int first_idx, output int nz_bad);
        nvalid    = 0;
        first_idx = -1;
        nz_bad    = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.dout_valid) begin
                if (first_idx < 0) first_idx = k;
                if (nvalid < 64) begin
                    for (int j = 0; j < 16; j++) begin
                        cap_i[nvalid][j] = bus.dout_i[j];
                        cap_q[nvalid][j] = bus.dout_q[j];
                    end
                end
                nvalid++;
            end else begin
                for (int j = 0; j < 16; j++)
                    if (bus.dout_i[j] != 0 || bus.dout_q[j] != 0) nz_bad++;
            end
            bus.start_trigger = (k < 256) ? pat[k] : 1'b0;
        end
        bus.start_trigger = 1'b0;
    endtask

    initial begin
        vec_t vecs [10];
        logic [255:0] pat;
        int nv, fi, nz, cnt;

`ifdef FPGA_TOP_BFLY_EN
        vecs[0] = '{"b0_l0", 0, 0, 3848, 765};
        vecs[1] = '{"b0_l8", 0, 8, 152, -765};
        vecs[2] = '{"b1_l0", 1, 0, 2179, 3262};
        vecs[3] = '{"b1_l8", 1, 8, 649, -434};
        vecs[4] = '{"b2_l0", 2, 0, -765, 3848};
        vecs[5] = '{"b2_l8", 2, 8, 765, 152};
        vecs[6] = '{"b4_l0", 4, 0, -3848, -765};
        vecs[7] = '{"b4_l8", 4, 8, -152, 765};
        vecs[8] = '{"b6_l0", 6, 0, 765, -3848};
        vecs[9] = '{"b6_l8", 6, 8, -765, -152};
`else
        vecs[0] = '{"b0_l0", 0, 0, 2000, 0};
        vecs[1] = '{"b0_l8", 0, 8, 1848, 765};
        vecs[2] = '{"b0_l4", 0, 4, 1962, 390};
        vecs[3] = '{"b1_l0", 1, 0, 1414, 1414};
        vecs[4] = '{"b1_l8", 1, 8, 765, 1848};
        vecs[5] = '{"b2_l0", 2, 0, 0, 2000};
        vecs[6] = '{"b2_l8", 2, 8, -765, 1848};
        vecs[7] = '{"b4_l0", 4, 0, -2000, 0};
        vecs[8] = '{"b6_l0", 6, 0, 0, -2000};
        vecs[9] = '{"b6_l8", 6, 8, 765, -1848};
`endif

        build_model();
        bus.start_trigger = 1'b0;

        #1;
        check_zero_now("reset_state");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single pulse: latency, length, idle zeros, contents.
        pat = '0;
        pat[0] = 1'b1;
        watch(60, pat, nv, fi, nz);
        check_int("burst_a_count", nv, 32);
        check_int("burst_a_first", fi, 3);
        check_int("burst_a_idle_zero", nz, 0);
        for (int i = 0; i < 10; i++) begin
            check_int({vecs[i].name, "_i"}, int'(cap_i[vecs[i].beat][vecs[i].lane]), vecs[i].want_i);
            check_int({vecs[i].name, "_q"}, int'(cap_q[vecs[i].beat][vecs[i].lane]), vecs[i].want_q);
        end
        for (int b = 0; b < 32; b++) check_beat("burst_a", b, b);

        // Pulse mid-burst ignored; pulse on first idle cycle starts an identical burst.
        pat = '0;
        pat[0]  = 1'b1;
        pat[13] = 1'b1;
        pat[33] = 1'b1;
        watch(100, pat, nv, fi, nz);
        check_int("retrig_count", nv, 64);
        check_int("retrig_first", fi, 3);
        check_int("retrig_idle_zero", nz, 0);
        for (int b = 0; b < 32; b++) check_beat("retrig_second", 32 + b, b);

        // Pulse seen on the last-beat cycle is dropped.
        pat = '0;
        pat[0]  = 1'b1;
        pat[32] = 1'b1;
        watch(100, pat, nv, fi, nz);
        check_int("lastbeat_pulse_count", nv, 32);

        // Held trigger gives one burst.
        pat = '0;
        for (int k = 0; k < 100; k++) pat[k] = 1'b1;
        watch(150, pat, nv, fi, nz);
        check_int("held_count", nv, 32);
        check_int("held_first", fi, 3);

        // Reset at beat 15 aborts the burst.
        @(negedge clk);
        bus.start_trigger = 1'b1;
        @(negedge clk);
        bus.start_trigger = 1'b0;
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 16; k++) begin
            @(negedge clk);
            if (bus.dout_valid) cnt++;
        end
        check_int("rst_reach_beat15", cnt, 16);
        rst = 1'b1;
        #1;
        check_zero_now("rst_mid_burst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pat = '0;
        watch(40, pat, nv, fi, nz);
        check_int("post_rst_no_beats", nv, 0);
        check_int("post_rst_zero", nz, 0);
        pat[0] = 1'b1;
        watch(60, pat, nv, fi, nz);
        check_int("post_rst_count", nv, 32);
        check_int("post_rst_first", fi, 3);
        check_beat("post_rst_b0", 0, 0);
        check_beat("post_rst_b31", 31, 31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
